mc_controller_p: RTL and testbench

//   Parametrised multicycle MIPS-subset control FSM, successor to the fixed 4-byte-fetch controller.

---
 rtl/mc_controller_p_if.sv | 35 +++
 rtl/mc_controller_p.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_controller_p.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_p_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// Carries the opcode/flag/handshake inputs and every control output of the FSM.
interface mc_controller_p_if #(
  parameter int FETCH_BEATS = 4,
  parameter int OPW         = 6
);
  logic [OPW-1:0]         op;
  logic                   zero;
  logic                   mem_ready;
  logic                   alusrca;
  logic [1:0]             alusrcb;
  logic [1:0]             aluop;
  logic                   pcen;
  logic                   iord;
  logic [FETCH_BEATS-1:0] irwrite;
  logic                   memread;
  logic                   memwrite;
  logic                   memtoreg;
  logic [1:0]             pcsource;
  logic                   regwrite;
  logic                   regdst;
  logic                   illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output alusrca, alusrcb, aluop, pcen, iord, irwrite, memread, memwrite,
           memtoreg, pcsource, regwrite, regdst, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  alusrca, alusrcb, aluop, pcen, iord, irwrite, memread, memwrite,
           memtoreg, pcsource, regwrite, regdst, illegal_op
  );
endinterface

// File: rtl/mc_controller_p.sv
// Multicycle MIPS-subset control FSM with multi-beat fetch and memory wait states.
// Optional BNE support is compiled in when CTRL_BNE_EN is defined.
module mc_controller_p #(
  parameter int FETCH_BEATS = 4,
  parameter int OPW         = 6
) (
  input  logic              clk,
  input  logic              reset,
  mc_controller_p_if.master bus
);

  localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`ifdef CTRL_BNE_EN
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
`ifdef CTRL_BNE_EN
    S_BNEEX   = 4'd11,
`endif
    S_ADDIWR  = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            op_known;

  logic                   alusrca, memread, memwrite, memtoreg, iord;
  logic                   regwrite, regdst, illegal_op, pcen;
  logic                   pcwrite, branch;
  logic [1:0]             alusrcb, aluop, pcsource;
  logic [FETCH_BEATS-1:0] irwrite;
`ifdef CTRL_BNE_EN
  logic                   branchn;
`endif

  always_comb begin
    op_known = 1'b0;
    case (bus.op)
      OP_RTYPE, OP_LB, OP_SB, OP_ADDI, OP_BEQ, OP_J: op_known = 1'b1;
`ifdef CTRL_BNE_EN
      OP_BNE:                                        op_known = 1'b1;
`endif
      default:                                       op_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DECODE;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LB, OP_SB, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = S_RTYPEEX;
          OP_BEQ:                state_d = S_BEQEX;
          OP_J:                  state_d = S_JEX;
`ifdef CTRL_BNE_EN
          OP_BNE:                state_d = S_BNEEX;
`endif
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (bus.op)
          OP_LB:   state_d = S_LBRD;
          OP_SB:   state_d = S_SBWR;
          OP_ADDI: state_d = S_ADDIWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_LBRD:    if (bus.mem_ready) state_d = S_LBWR;
      S_SBWR:    if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_LBWR, S_RTYPEWR, S_BEQEX, S_JEX, S_ADDIWR: state_d = S_FETCH;
`ifdef CTRL_BNE_EN
      S_BNEEX:   state_d = S_FETCH;
`endif
      default: begin
        state_d = S_FETCH;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs decode from the current state; holding reset low masks them all.
  always_comb begin
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    iord       = 1'b0;
    irwrite    = '0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    pcsource   = 2'b00;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef CTRL_BNE_EN
    branchn    = 1'b0;
`endif
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          if (bus.mem_ready) begin
            irwrite = FETCH_BEATS'(1) << beat_q;
            pcwrite = 1'b1;
          end
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = ~op_known;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RTYPEWR: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca  = 1'b1;
          aluop    = 2'b01;
          branch   = 1'b1;
          pcsource = 2'b01;
        end
        S_JEX: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_ADDIWR: regwrite = 1'b1;
`ifdef CTRL_BNE_EN
        S_BNEEX: begin
          alusrca  = 1'b1;
          aluop    = 2'b01;
          branchn  = 1'b1;
          pcsource = 2'b01;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef CTRL_BNE_EN
  assign pcen = pcwrite | (branch & bus.zero) | (branchn & ~bus.zero);
`else
  assign pcen = pcwrite | (branch & bus.zero);
`endif

  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.aluop      = aluop;
  assign bus.pcen       = pcen;
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.memread    = memread;
  assign bus.memwrite   = memwrite;
  assign bus.memtoreg   = memtoreg;
  assign bus.pcsource   = pcsource;
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_mc_controller_p.sv
// Scoreboard bench for mc_controller_p: directed per-cycle vectors feed an expected queue
// that a negedge monitor drains against the full control output word.
module tb_mc_controller_p;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_controller_p_if #(.FETCH_BEATS(4), .OPW(6)) bus ();
  mc_controller_p #(.FETCH_BEATS(4), .OPW(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [18:0] act;

  assign act = {bus.alusrca, bus.alusrcb, bus.aluop, bus.pcen, bus.iord, bus.irwrite,
                bus.memread, bus.memwrite, bus.memtoreg, bus.pcsource, bus.regwrite,
                bus.regdst, bus.illegal_op};

  // {alusrca, alusrcb, aluop, pcen, iord, irwrite, memread, memwrite, memtoreg, pcsource, regwrite, regdst, illegal_op}
  function automatic logic [18:0] ev(input logic a, input logic [1:0] b, input logic [1:0] op,
                                     input logic pc, input logic io, input logic [3:0] irw,
                                     input logic mr, input logic mw, input logic mtr,
                                     input logic [1:0] ps, input logic rw, input logic rd,
                                     input logic il);
    return {a, b, op, pc, io, irw, mr, mw, mtr, ps, rw, rd, il};
  endfunction

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic [18:0] E_ZERO, E_FWAIT, E_DEC, E_DEC_ILL, E_MEMADR, E_LBRD, E_LBWR, E_SBWR;
  logic [18:0] E_RTEX, E_RTWR, E_BEQ_T, E_BEQ_N, E_JEX, E_ADDIWR;

  initial begin
    E_ZERO    = '0;
    E_FWAIT   = ev(0, 2'b01, 2'b00, 0, 0, 4'b0000, 1, 0, 0, 2'b00, 0, 0, 0);
    E_DEC     = ev(0, 2'b11, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0);
    E_DEC_ILL = ev(0, 2'b11, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 1);
    E_MEMADR  = ev(1, 2'b10, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0);
    E_LBRD    = ev(0, 2'b00, 2'b00, 0, 1, 4'b0000, 1, 0, 0, 2'b00, 0, 0, 0);
    E_LBWR    = ev(0, 2'b00, 2'b00, 0, 0, 4'b0000, 0, 0, 1, 2'b00, 1, 0, 0);
    E_SBWR    = ev(0, 2'b00, 2'b00, 0, 1, 4'b0000, 0, 1, 0, 2'b00, 0, 0, 0);
    E_RTEX    = ev(1, 2'b00, 2'b10, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0);
    E_RTWR    = ev(0, 2'b00, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 1, 1, 0);
    E_BEQ_T   = ev(1, 2'b00, 2'b01, 1, 0, 4'b0000, 0, 0, 0, 2'b01, 0, 0, 0);
    E_BEQ_N   = ev(1, 2'b00, 2'b01, 0, 0, 4'b0000, 0, 0, 0, 2'b01, 0, 0, 0);
    E_JEX     = ev(0, 2'b00, 2'b00, 1, 0, 4'b0000, 0, 0, 0, 2'b10, 0, 0, 0);
    E_ADDIWR  = ev(0, 2'b00, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 1, 0, 0);
  end

  function automatic logic [18:0] e_fetch(input logic [3:0] irw);
    return ev(0, 2'b01, 2'b00, 1, 0, irw, 1, 0, 0, 2'b00, 0, 0, 0);
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic rdy,
                      input logic [18:0] e, input string nm);
    @(posedge clk);
    #1;
    reset         = r;
    bus.op        = o;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch4(input logic [5:0] o);
    for (int b = 0; b < 4; b++)
      step(1, o, 0, 1, e_fetch(4'(1 << b)), "fetch_beat");
  endtask

  initial begin : monitor
    logic [18:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    step(0, OP_LB, 0, 1, E_ZERO, "reset_low");
    step(0, OP_LB, 1, 1, E_ZERO, "reset_low2");

    // irwrite stepping with wait states
    step(1, OP_LB, 0, 1, e_fetch(4'b0001), "fw_b0");
    step(1, OP_LB, 0, 0, E_FWAIT,          "fw_wait1");
    step(1, OP_LB, 0, 1, e_fetch(4'b0010), "fw_b1");
    step(1, OP_LB, 0, 1, e_fetch(4'b0100), "fw_b2");
    step(1, OP_LB, 0, 0, E_FWAIT,          "fw_wait2");
    step(1, OP_LB, 0, 1, e_fetch(4'b1000), "fw_b3");
    step(1, OP_LB, 0, 1, E_DEC,            "lb_decode");
    step(1, OP_LB, 0, 1, E_MEMADR,         "lb_memadr");
    step(1, OP_LB, 0, 0, E_LBRD,           "lb_rd_wait");
    step(1, OP_LB, 0, 0, E_LBRD,           "lb_rd_wait2");
    // reset in the middle of the load read
    step(0, OP_LB, 0, 0, E_ZERO,           "midrst");
    step(0, OP_LB, 0, 1, E_ZERO,           "midrst_rdy");
    step(1, OP_LB, 0, 0, E_FWAIT,          "post_rst_wait");
    step(1, OP_LB, 0, 1, e_fetch(4'b0001), "post_rst_b0");
    step(1, OP_LB, 0, 1, e_fetch(4'b0010), "post_rst_b1");
    step(1, OP_LB, 0, 1, e_fetch(4'b0100), "post_rst_b2");
    step(1, OP_LB, 0, 1, e_fetch(4'b1000), "post_rst_b3");
    step(1, OP_LB, 0, 1, E_DEC,            "lb2_decode");
    step(1, OP_LB, 0, 1, E_MEMADR,         "lb2_memadr");
    step(1, OP_LB, 0, 1, E_LBRD,           "lb2_rd");
    step(1, OP_LB, 0, 1, E_LBWR,           "lb2_wr");

    fetch4(OP_ADDI);
    step(1, OP_ADDI, 0, 1, E_DEC,    "addi_decode");
    step(1, OP_ADDI, 0, 1, E_MEMADR, "addi_memadr");
    step(1, OP_ADDI, 0, 1, E_ADDIWR, "addi_wr");
    step(1, OP_ADDI, 0, 0, E_FWAIT,  "addi_back_fetch");
    step(1, OP_ADDI, 0, 1, e_fetch(4'b0001), "addi_f0");
    step(1, OP_ADDI, 0, 1, e_fetch(4'b0010), "addi_f1");
    step(1, OP_ADDI, 0, 1, e_fetch(4'b0100), "addi_f2");
    step(1, OP_ADDI, 0, 1, e_fetch(4'b1000), "addi_f3");
    step(1, OP_BEQ, 1, 1, E_DEC,     "beq_t_decode");
    step(1, OP_BEQ, 1, 1, E_BEQ_T,   "beq_taken");

    fetch4(OP_BEQ);
    step(1, OP_BEQ, 0, 1, E_DEC,     "beq_n_decode");
    step(1, OP_BEQ, 0, 1, E_BEQ_N,   "beq_not_taken");

    fetch4(OP_SB);
    step(1, OP_SB, 0, 1, E_DEC,      "sb_decode");
    step(1, OP_SB, 0, 1, E_MEMADR,   "sb_memadr");
    step(1, OP_SB, 0, 0, E_SBWR,     "sb_wait1");
    step(1, OP_SB, 0, 0, E_SBWR,     "sb_wait2");
    step(1, OP_SB, 0, 0, E_SBWR,     "sb_wait3");
    step(1, OP_SB, 0, 1, E_SBWR,     "sb_done");
    step(1, OP_SB, 0, 0, E_FWAIT,    "sb_back_fetch");
    step(1, OP_RTYPE, 0, 1, e_fetch(4'b0001), "rt_f0");
    step(1, OP_RTYPE, 0, 1, e_fetch(4'b0010), "rt_f1");
    step(1, OP_RTYPE, 0, 1, e_fetch(4'b0100), "rt_f2");
    step(1, OP_RTYPE, 0, 1, e_fetch(4'b1000), "rt_f3");
    step(1, OP_RTYPE, 1, 0, E_DEC,   "rt_decode");
    step(1, OP_RTYPE, 0, 1, E_RTEX,  "rt_ex");
    step(1, OP_RTYPE, 0, 1, E_RTWR,  "rt_wr");

    fetch4(OP_J);
    step(1, OP_J, 0, 1, E_DEC,       "j_decode");
    step(1, OP_J, 0, 0, E_JEX,       "j_ex");

    fetch4(OP_BNE);
`ifdef CTRL_BNE_EN
    step(1, OP_BNE, 0, 1, E_DEC,     "bne_decode");
    step(1, OP_BNE, 0, 1, E_BEQ_T,   "bne_taken");
`else
    step(1, OP_BNE, 0, 1, E_DEC_ILL, "bne_illegal");
`endif
    step(1, OP_BNE, 0, 0, E_FWAIT,   "bne_back_fetch");

    fetch4(6'b111111);
    step(1, 6'b111111, 0, 1, E_DEC_ILL, "illegal_decode");
    step(1, 6'b111111, 0, 0, E_FWAIT,   "illegal_back_fetch");

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
